serial_div_ctrl: RTL and testbench
==================================

Name: serial_div_ctrl

Overview:
Controller for a programmable frequency divider with a serial configuration port. It shifts in a W-bit divide value MSB-first and holds it in a config register. A reload-on-carry up-counter is loaded with either that value (mode=1) or the fixed value 128 (mode=0), producing a periodic tick and a toggled divided output. It sits between the lab's serial input, mode select and the clock/waveform output stage.

Parameters:
W, 8, width of the config value, shift register and divide counter. The fixed value 128 requires W >= 8.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
start  in  1  single-cycle pulse that begins a configuration frame
sdata  in  1  serial config bit, MSB first
sen  in  1  sdata valid qualifier
mode  in  1  1: divide value = cfg; 0: divide value = 128
run  in  1  divider enable
busy  out  1  high while a frame is being shifted in (state SHIFT)
cfg_done  out  1  one-cycle pulse in state COMMIT
cfg  out  W  committed divide value
cnt  out  W  divider counter value
tick  out  1  combinational: run && (cnt == all ones)
div_out  out  1  toggles on every tick

Behaviour:
- Reset (async): state=IDLE; shift reg=0; bit count=0; cfg=0; cnt=0; div_out=0; busy=0; cfg_done=0.
- Active value L = mode ? cfg : 128.
- Config FSM: IDLE, SHIFT, COMMIT.
  - IDLE: start=1 -> SHIFT, bit count cleared. sen in this cycle is ignored; no bit is captured.
  - SHIFT: busy=1. When sen=1, shreg <= {shreg[W-2:0], sdata} and bit count +1. On the edge that accepts the W-th bit, cfg <= {shreg[W-2:0], sdata} and the FSM moves to COMMIT. When sen=0, shreg and bit count hold.
  - SHIFT with start=1: the frame restarts. Bit count=0, and any sdata/sen in that cycle is discarded.
  - COMMIT: cfg_done=1 for exactly one cycle; cfg already holds the new value. Next state is IDLE. start in COMMIT is ignored.
- Divider, evaluated each clock edge:
  - run=0: cnt <= L (init/load); div_out holds; tick=0.
  - run=1 and cnt != all ones: cnt <= cnt+1.
  - run=1 and cnt == all ones: tick=1; cnt <= L (reload); div_out <= ~div_out.
  - Tick period = 2^W - L cycles; div_out period = 2*(2^W - L).
  - L = all ones: tick stays high every cycle and div_out toggles every cycle.
  - L = 0: period is 2^W.
- A cfg or mode change while run=1 takes effect only at the next reload; the current count is not disturbed.
- Config FSM and divider are independent. Shifting a frame does not stall the divider.
- rst mid-frame or mid-run: immediate return to reset values; any partial frame is lost.
- mode=1 before any commit: L=0 (cfg reset value).

Test Plan:
- Reset: assert rst mid-activity, asynchronously -> all outputs 0 within the same cycle, state IDLE. After release with run=0, mode=0 -> cnt=128 after one edge.
- mode=0, run held 0 then 1 (W=8) -> tick first asserts in the 128th cycle with run high, then every 128 cycles; div_out period 256.
- Frame: start, then 8 bits of 0xF0 with sen gaps of 0–3 cycles -> busy high throughout; cfg=0xF0 and cfg_done high for 1 cycle immediately after the 8th accepted bit. Then mode=1, run=1 -> tick every 16 cycles, div_out period 32.
- Frame 0xFF, mode=1, run=1 -> tick constantly 1, div_out toggles every cycle. Frame 0x00 -> tick every 256 cycles.
- start re-pulsed after 3 bits of a frame -> restart; the following 8 bits 0xA5 give cfg=0xA5 with no residue from the aborted bits.
- Commit 0xC0 while running with L=0xF0 -> current 16-cycle period completes, next period is 64 cycles. Toggling mode mid-period behaves the same way (change applies at the next reload).

Source files
------------

// File: rtl/serial_div_ctrl_if.sv
// Handshake/data bundle between the lab front end and serial_div_ctrl.
// Master drives the config/control inputs; slave returns status and divider state.
interface serial_div_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic         sdata;
  logic         sen;
  logic         mode;
  logic         run;
  logic         busy;
  logic         cfg_done;
  logic [W-1:0] cfg;
  logic [W-1:0] cnt;
  logic         tick;
  logic         div_out;

  modport master (
    output start, sdata, sen, mode, run,
    input  busy, cfg_done, cfg, cnt, tick, div_out
  );

  modport slave (
    input  start, sdata, sen, mode, run,
    output busy, cfg_done, cfg, cnt, tick, div_out
  );
endinterface

// File: rtl/serial_div_ctrl.sv
// Serial-configured programmable divider: MSB-first config shift-in plus
// a reload-on-carry up-counter producing a tick and a toggled output.
module serial_div_ctrl #(
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  serial_div_ctrl_if.slave bus
);
  localparam int BW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-2:0]  r_shreg;
  logic [BW-1:0] r_bcnt;
  logic [W-1:0]  r_cfg;
  logic [W-1:0]  r_cnt;
  logic          r_div;
  logic [W-1:0]  w_load;
  logic          w_clr;
  logic          w_shift;
  logic          w_last;
  logic          w_max;
  logic          w_tick;

  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_shift = 1'b0;
    w_last  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = SHIFT;
          w_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.start) begin
          w_clr = 1'b1;
        end else if (bus.sen) begin
          w_shift = 1'b1;
          if (r_bcnt == BW'(W - 1)) begin
            w_last = 1'b1;
            w_next = COMMIT;
          end
        end
      end
      COMMIT: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Only W-1 bits are kept: the W-th bit goes straight into cfg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_bcnt  <= '0;
      r_cfg   <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_bcnt <= '0;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[W-3:0], bus.sdata};
        r_bcnt  <= r_bcnt + 1'b1;
      end
      if (w_last) begin
        r_cfg <= {r_shreg, bus.sdata};
      end
    end
  end

  assign w_load = bus.mode ? r_cfg : W'(128);
  assign w_max  = &r_cnt;
  assign w_tick = bus.run && w_max;

  // New cfg/mode only enters the count through a load or reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (!bus.run) begin
      r_cnt <= w_load;
    end else if (w_max) begin
      r_cnt <= w_load;
      r_div <= ~r_div;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.busy     = (r_state == SHIFT);
  assign bus.cfg_done = (r_state == COMMIT);
  assign bus.cfg      = r_cfg;
  assign bus.cnt      = r_cnt;
  assign bus.tick     = w_tick;
  assign bus.div_out  = r_div;
endmodule

// File: tb/tb_serial_div_ctrl.sv
// Directed bench for serial_div_ctrl: frame vector table plus
// tick/div_out period windows and reset corner cases.
module tb_serial_div_ctrl;
  logic clk;
  logic rst;
  int   nvec;
  int   nfail;
  logic exp_div;

  serial_div_ctrl_if #(.W(8)) bus ();

  serial_div_ctrl #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       sen;
    logic       sdata;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_cfg;
  } vec_t;

  vec_t vt [18];

  function automatic logic [19:0] bund();
    return {bus.busy, bus.cfg_done, bus.cfg, bus.cnt, bus.tick, bus.div_out};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] v, input bit gaps,
                            input bit noise);
    int bad;
    bad = 0;
    bus.start = 1'b1;
    bus.sen   = noise;
    bus.sdata = noise;
    edge1();
    bus.start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bus.sen   = 1'b1;
      bus.sdata = v[i];
      edge1();
      bus.sen   = 1'b0;
      if (i > 0) begin
        if (bus.busy !== 1'b1 || bus.cfg_done !== 1'b0) bad++;
        repeat (gaps ? (i % 4) : 0) begin
          edge1();
          if (bus.busy !== 1'b1 || bus.cfg_done !== 1'b0) bad++;
        end
      end
    end
    chk("frame_commit", {bus.busy, bus.cfg_done, bus.cfg},
        {1'b0, 1'b1, v});
    chk("frame_busy_errs", bad, 0);
    edge1();
    chk("frame_done_drop", {bus.busy, bus.cfg_done, bus.cfg},
        {1'b0, 1'b0, v});
  endtask

  // Ticks expected at first, first+p1, then every p2.
  task automatic window(input string nm, input int n, input int first,
                        input int p1, input int p2);
    int nxt;
    int ntk;
    int bad;
    int bk;
    logic [1:0] ba;
    logic [1:0] be;
    nxt = first;
    ntk = 0;
    bad = 0;
    bk  = 0;
    ba  = '0;
    be  = '0;
    bus.run = 1'b1;
    for (int k = 1; k <= n; k++) begin
      #1;
      if (bus.tick !== (k == nxt) || bus.div_out !== exp_div) begin
        if (bad == 0) begin
          bk = k;
          ba = {bus.tick, bus.div_out};
          be = {logic'(k == nxt), exp_div};
        end
        bad++;
      end
      if (k == nxt) begin
        exp_div = ~exp_div;
        ntk++;
        nxt = nxt + ((ntk == 1) ? p1 : p2);
      end
      edge1();
    end
    bus.run = 1'b0;
    nvec++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL %s: %0d bad cycles, first at cycle %0d tick/div got %b want %b",
               nm, bad, bk, ba, be);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nvec    = 0;
    nfail   = 0;
    exp_div = 1'b0;
    vt = '{
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0}
    };

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sen   = 1'b0;
    bus.sdata = 1'b0;
    bus.mode  = 1'b0;
    bus.run   = 1'b0;
    repeat (2) edge1();
    chk("reset_state", bund(), 20'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      bus.start = vt[i].start;
      bus.sen   = vt[i].sen;
      bus.sdata = vt[i].sdata;
      edge1();
      chk($sformatf("vec%0d", i), bund(),
          {vt[i].e_busy, vt[i].e_done, vt[i].e_cfg, 8'd128, 1'b0, exp_div});
    end
    bus.start = 1'b0;
    bus.sen   = 1'b0;

    window("mode0_128", 400, 128, 128, 128);

    bus.mode = 1'b1;
    edge1();
    chk("load_f0", bus.cnt, 8'hF0);
    window("cfg_f0", 70, 16, 16, 16);

    send_frame(8'hFF, 1'b1, 1'b0);
    edge1();
    window("cfg_ff", 20, 1, 1, 1);

    send_frame(8'h00, 1'b0, 1'b0);
    edge1();
    window("cfg_00", 520, 256, 256, 256);

    bus.start = 1'b1;
    edge1();
    bus.start = 1'b0;
    bus.sen   = 1'b1;
    bus.sdata = 1'b1;
    repeat (3) edge1();
    send_frame(8'hA5, 1'b0, 1'b1);

    send_frame(8'hF0, 1'b1, 1'b0);
    edge1();
    fork
      window("cfg_change_run", 170, 16, 16, 64);
      begin
        repeat (17) @(posedge clk);
        #1;
        send_frame(8'hC0, 1'b0, 1'b0);
      end
    join

    edge1();
    chk("load_c0", bus.cnt, 8'hC0);
    fork
      window("mode_change_run", 260, 64, 64, 128);
      begin
        repeat (79) @(posedge clk);
        #1;
        bus.mode = 1'b0;
      end
    join

    bus.start = 1'b1;
    edge1();
    bus.start = 1'b0;
    bus.sen   = 1'b1;
    bus.sdata = 1'b1;
    repeat (2) edge1();
    bus.sen = 1'b0;
    bus.run = 1'b1;
    repeat (2) edge1();
    #2;
    rst = 1'b1;
    #1;
    exp_div = 1'b0;
    chk("async_reset", bund(), 20'h0);
    bus.run  = 1'b0;
    bus.mode = 1'b0;
    #1;
    rst = 1'b0;
    edge1();
    chk("post_reset_load", bund(), {2'b00, 8'h00, 8'd128, 2'b00});
    bus.mode = 1'b1;
    edge1();
    chk("mode1_cfg0", bund(), 20'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
